ft601_tx_ctrl: RTL



---
 rtl/ft601_tx_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ft601_tx_ctrl.sv
// FT601 245-mode synchronous write master: pops a show-ahead source and bursts words onto the FTDI bus.
// Optional statistics counters are enabled with `define FT_TX_STATS_EN.
module ft601_tx_ctrl #(
   parameter int FT_DATA_WIDTH = 32,
   parameter int BE_WIDTH      = 4,
   parameter int BURST_LEN     = 4097
) (
   input  logic                     clk_i,
   input  logic                     reset_n,
   input  logic [FT_DATA_WIDTH-1:0] src_data_i,
   input  logic                     src_empty_i,
   input  logic                     src_enough_i,
   output logic                     src_re_o,
   input  logic                     ft_txe_n_i,
   output logic                     ft_wr_n_o,
   output logic [FT_DATA_WIDTH-1:0] ft_data_o,
   output logic [BE_WIDTH-1:0]      ft_be_o,
   output logic                     ft_oe_o,
   output logic                     busy_o,
   output logic                     short_burst_o,
   output logic [31:0]              words_sent_o,
   output logic [31:0]              stall_cycles_o
);

   localparam logic [12:0] BURST_LEN_C  = 13'(BURST_LEN);
   localparam logic [12:0] BURST_LAST_C = 13'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t                     state_r;
   state_t                     state_nxt_s;
   logic                       out_valid_r;
   logic                       out_valid_nxt_s;
   logic [FT_DATA_WIDTH-1:0]   data_r;
   logic [12:0]                ld_cnt_r;
   logic [12:0]                acc_cnt_r;
   logic                       wr_n_r;
   logic [BE_WIDTH-1:0]        be_r;
   logic                       oe_r;
   logic                       busy_r;
   logic                       short_r;
   logic                       accept_s;
   logic                       load_s;
   logic                       slot_free_s;
   logic                       underrun_s;
   logic                       full_done_s;
   logic                       start_s;

   // Handshake decode: a word leaves when accepted, a new one enters when the slot is or becomes free.
   always_comb begin
      accept_s    = out_valid_r & ~ft_txe_n_i;
      slot_free_s = ~out_valid_r | accept_s;
      load_s      = (state_r == ST_WRITE) & ~src_empty_i & (ld_cnt_r < BURST_LEN_C) & slot_free_s;
      full_done_s = accept_s & (acc_cnt_r == BURST_LAST_C);
      underrun_s  = (state_r == ST_WRITE) & slot_free_s & src_empty_i & (ld_cnt_r < BURST_LEN_C);
      start_s     = src_enough_i & ~ft_txe_n_i;
   end

   assign src_re_o = load_s;

   // Next-state and next output-register occupancy.
   always_comb begin
      state_nxt_s     = state_r;
      out_valid_nxt_s = out_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s = ST_WRITE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (full_done_s || underrun_s) begin
               state_nxt_s = ST_TURN;
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_TURN: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (load_s) begin
         out_valid_nxt_s = 1'b1;
      end else if (accept_s) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
   end

   // State, hold-on-stall output word, burst counters and registered bus controls.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
         data_r      <= '0;
         ld_cnt_r    <= 13'd0;
         acc_cnt_r   <= 13'd0;
         wr_n_r      <= 1'b1;
         be_r        <= '0;
         oe_r        <= 1'b0;
         busy_r      <= 1'b0;
         short_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         if (load_s) begin
            data_r <= src_data_i;
         end
         if (state_r == ST_IDLE) begin
            ld_cnt_r  <= 13'd0;
            acc_cnt_r <= 13'd0;
         end else begin
            if (load_s) begin
               ld_cnt_r <= ld_cnt_r + 13'd1;
            end
            if (accept_s) begin
               acc_cnt_r <= acc_cnt_r + 13'd1;
            end
         end
         wr_n_r  <= ~out_valid_nxt_s;
         be_r    <= {BE_WIDTH{out_valid_nxt_s}};
         oe_r    <= (state_nxt_s != ST_IDLE);
         busy_r  <= (state_nxt_s != ST_IDLE);
         short_r <= underrun_s;
      end
   end

   assign ft_wr_n_o     = wr_n_r;
   assign ft_data_o     = data_r;
   assign ft_be_o       = be_r;
   assign ft_oe_o       = oe_r;
   assign busy_o        = busy_r;
   assign short_burst_o = short_r;

`ifdef FT_TX_STATS_EN
   logic [31:0] words_sent_r;
   logic [31:0] stall_cycles_r;

   // Free-running accept and stall counters, cleared only by reset.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         words_sent_r   <= 32'd0;
         stall_cycles_r <= 32'd0;
      end else begin
         if (accept_s) begin
            words_sent_r <= words_sent_r + 32'd1;
         end
         if ((state_r == ST_WRITE) && out_valid_r && ft_txe_n_i) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end
      end
   end

   assign words_sent_o   = words_sent_r;
   assign stall_cycles_o = stall_cycles_r;
`else
   assign words_sent_o   = 32'd0;
   assign stall_cycles_o = 32'd0;
`endif

endmodule
